lut_config_loader: RTL and testbench

//  Streams a configuration bitstream into a serial chain of NUM_LUTS LUTs.
//  The chain is daisy-chained config_out -> config_in, and each LUT shifts

---
 rtl/lut_config_loader_if.sv | 13 +
 rtl/lut_config_loader.sv | 114 +++++++++++
 tb/tb_lut_config_loader.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/lut_config_loader_if.sv
// Bitstream word channel between the host and the LUT config loader.
// Ports: s_valid/s_data driven by the host, s_ready returned by the loader.
// Latency: none, wires only. Backpressure: the host holds s_data until s_valid & s_ready.
interface lut_config_loader_if #(
  parameter int CW = 8
);
  logic          s_valid;
  logic [CW-1:0] s_data;
  logic          s_ready;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/lut_config_loader.sv
// Purpose: streams WORDS config words into a daisy-chained LUT config chain and
//   then checks an XOR checksum trailer word, reporting done or error.
// Latency: a LOAD handshake appears on config_en/config_in one cycle later.
// Backpressure: s_ready is high only in LOAD/CHECK; a low s_valid stalls in place.
// Ports: config_clk, config_rst_n (async, active low), start (pulse), abort (level),
//   s_bus (slave: s_valid, s_data, s_ready), config_en/config_in (chain head),
//   busy/done/error status, words_loaded (data words shifted since last start).
module lut_config_loader #(
  parameter int CONFIG_WIDTH = 8,
  parameter int MEM_SIZE     = 16,
  parameter int NUM_LUTS     = 4,
  localparam int WORDS = NUM_LUTS * MEM_SIZE / CONFIG_WIDTH,
  localparam int CNT_W = $clog2(WORDS + 1)
) (
  input  logic                    config_clk,
  input  logic                    config_rst_n,
  input  logic                    start,
  input  logic                    abort,
  lut_config_loader_if.slave      s_bus,
  output logic                    config_en,
  output logic [CONFIG_WIDTH-1:0] config_in,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic [CNT_W-1:0]        words_loaded
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CHECK = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERROR = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS - 1);
  localparam logic [CNT_W-1:0] ALL_WORDS = CNT_W'(WORDS);

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [CONFIG_WIDTH-1:0] csum_q, csum_d;
  logic                    cfg_en_q, cfg_en_d;
  logic [CONFIG_WIDTH-1:0] cfg_in_q, cfg_in_d;

  logic s_ready_c;
  logic hs;

  assign s_bus.s_ready = s_ready_c;
  assign hs            = s_bus.s_valid & s_ready_c;

  // State register plus datapath flops.
  always_ff @(posedge config_clk or negedge config_rst_n) begin
    if (!config_rst_n) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      csum_q   <= '0;
      cfg_en_q <= 1'b0;
      cfg_in_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      csum_q   <= csum_d;
      cfg_en_q <= cfg_en_d;
      cfg_in_q <= cfg_in_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    csum_d   = csum_q;
    cfg_en_d = 1'b0;
    cfg_in_d = cfg_in_q;
    unique case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        // abort beats a simultaneous start, so nothing is cleared then.
        if (start && !abort) begin
          state_d = ST_LOAD;
          count_d = '0;
          csum_d  = '0;
        end
      end
      ST_LOAD: begin
        if (hs) begin
          cfg_en_d = 1'b1;
          cfg_in_d = s_bus.s_data;
          csum_d   = csum_q ^ s_bus.s_data;
          if (count_q < ALL_WORDS) count_d = count_q + CNT_W'(1);
          if (count_q == LAST_WORD) state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        // Trailer word is compared only; it never reaches the chain.
        if (hs) state_d = (s_bus.s_data == csum_q) ? ST_DONE : ST_ERROR;
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort) state_d = ST_IDLE;
  end

  // Outputs decoded from the registered state.
  always_comb begin
    s_ready_c = (state_q == ST_LOAD) || (state_q == ST_CHECK);
    busy      = s_ready_c;
    done      = (state_q == ST_DONE);
    error     = (state_q == ST_ERROR);
  end

  assign config_en    = cfg_en_q;
  assign config_in    = cfg_in_q;
  assign words_loaded = count_q;

endmodule

// File: tb/tb_lut_config_loader.sv
// Scoreboard bench for lut_config_loader: data handshakes push the expected chain
// word, each config_en pop-compares it, and status is checked after each load.
module tb_lut_config_loader;

  localparam int CW    = 8;
  localparam int WORDS = 8;
  localparam int CNT_W = $clog2(WORDS + 1);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             config_en;
  logic [CW-1:0]    config_in;
  logic             busy, done, error;
  logic [CNT_W-1:0] words_loaded;

  lut_config_loader_if #(.CW(CW)) bus ();

  lut_config_loader #(.CONFIG_WIDTH(CW), .MEM_SIZE(16), .NUM_LUTS(4)) dut (
    .config_clk   (clk),
    .config_rst_n (rst_n),
    .start        (start),
    .abort        (abort),
    .s_bus        (bus),
    .config_en    (config_en),
    .config_in    (config_in),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int en_count = 0;
  int hs_count = 0;
  bit data_phase = 1'b0;
  bit pending = 1'b0;
  logic [CW-1:0] sb[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Monitor: sample mid-cycle. A data handshake about to happen at the next
  // rising edge must show up on config_en one sample later.
  always @(negedge clk) begin
    if (!rst_n) begin
      pending = 1'b0;
      sb.delete();
    end else begin
      check("cfg_en_timing", 32'(config_en), 32'(pending));
      if (config_en) begin
        en_count++;
        if (sb.size() == 0) check("sb_underflow", 32'd1, 32'd0);
        else check("cfg_in", 32'(config_in), 32'(sb.pop_front()));
      end
      pending = bus.s_valid && bus.s_ready && data_phase;
      if (pending) begin
        hs_count++;
        sb.push_back(bus.s_data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [CW-1:0] d, input bit is_data, input int max_stall);
    int n = 0;
    repeat ($urandom_range(0, max_stall)) tick();
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    data_phase  = is_data;
    @(negedge clk);
    while (!bus.s_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.s_ready) check("ready_timeout", 32'd0, 32'd1);
    tick();
    bus.s_valid = 1'b0;
    data_phase  = 1'b0;
  endtask

  task automatic send_words(input int first, input int last, input int max_stall);
    for (int i = first; i <= last; i++) send(CW'(i), 1'b1, max_stall);
  endtask

  function automatic logic [CW-1:0] xor_1_to_n(input int n);
    logic [CW-1:0] x = '0;
    for (int i = 1; i <= n; i++) x ^= CW'(i);
    return x;
  endfunction

  task automatic check_end(input string tag, input bit exp_done, input bit exp_err);
    tick();
    check({tag, "_done"}, 32'(done), 32'(exp_done));
    check({tag, "_error"}, 32'(error), 32'(exp_err));
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_words"}, 32'(words_loaded), WORDS);
    check({tag, "_shifts"}, en_count, WORDS);
    check({tag, "_sb_empty"}, sb.size(), 0);
  endtask

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    repeat (3) tick();
    // Reset state
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(bus.s_ready), 32'd0);
    check("rst_words", 32'(words_loaded), 32'd0);
    rst_n = 1'b1;
    tick();

    // T1: reset asserted mid-load clears outputs without a clock edge
    pulse_start();
    send_words(1, 3, 0);
    bus.s_valid = 1'b1;
    bus.s_data  = 8'hAA;
    #2;
    rst_n = 1'b0;
    #1;
    check("t1_en", 32'(config_en), 32'd0);
    check("t1_in", 32'(config_in), 32'd0);
    check("t1_flags", {busy, done, error, bus.s_ready}, 32'd0);
    check("t1_words", 32'(words_loaded), 32'd0);
    bus.s_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // T2: happy path
    en_count = 0;
    pulse_start();
    check("t2_busy", 32'(busy), 32'd1);
    send_words(1, WORDS, 0);
    check("t2_check_words", 32'(words_loaded), WORDS);
    send(xor_1_to_n(WORDS), 1'b0, 0);
    check("t2_trailer", 32'(xor_1_to_n(WORDS)), 32'h08);
    check_end("t2", 1'b1, 1'b0);

    // T3: bad checksum, trailer must not shift
    en_count = 0;
    pulse_start();
    check("t3_done_cleared", 32'(done), 32'd0);
    send_words(1, WORDS, 0);
    send(8'hFF, 1'b0, 0);
    check_end("t3", 1'b0, 1'b1);

    // T4: random stalls
    en_count = 0;
    hs_count = 0;
    pulse_start();
    send_words(1, WORDS, 3);
    send(xor_1_to_n(WORDS), 1'b0, 3);
    check_end("t4", 1'b1, 1'b0);
    check("t4_hs_vs_en", en_count, hs_count);

    // T5: abort after 3 words, then a full reload
    en_count = 0;
    pulse_start();
    send_words(1, 3, 0);
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    check("t5_ready", 32'(bus.s_ready), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_words", 32'(words_loaded), 32'd3);
    tick();
    check("t5_shifts", en_count, 3);
    en_count = 0;
    pulse_start();
    send_words(1, WORDS, 1);
    send(xor_1_to_n(WORDS), 1'b0, 1);
    check_end("t5b", 1'b1, 1'b0);

    // T6: start while busy is ignored; start in DONE restarts
    en_count = 0;
    pulse_start();
    send_words(1, 4, 0);
    pulse_start();
    check("t6_words_kept", 32'(words_loaded), 32'd4);
    send_words(5, WORDS, 0);
    send(xor_1_to_n(WORDS), 1'b0, 0);
    check_end("t6", 1'b1, 1'b0);
    en_count = 0;
    pulse_start();
    check("t6_restart_done", 32'(done), 32'd0);
    check("t6_restart_busy", 32'(busy), 32'd1);
    check("t6_restart_words", 32'(words_loaded), 32'd0);
    send_words(1, WORDS, 0);
    send(xor_1_to_n(WORDS), 1'b0, 0);
    check_end("t6b", 1'b1, 1'b0);

    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
